equal_opp_rr_arbiter: RTL and testbench

- Parametrised N-channel fair-access arbiter: grants one requester at a time, one-hot, with a bounded wait for every channel.
- Two modes:
  - fixed time-slot rotation, which is non-work-conserving;
  - work-conserving round-robin with a per-grant quantum.
- Tracks per-channel wait time and flags starvation so formal/sim fairness properties can be checked directly.
- Sits between request sources and a shared resource.

---
 rtl/equal_opp_pkg.sv | 19 +
 rtl/rr_picker.sv | 31 +++
 rtl/equal_opp_rr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_equal_opp_rr_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/equal_opp_pkg.sv
// rtl/equal_opp_pkg.sv - shared types and helpers for the equal-opportunity arbiter
package equal_opp_pkg;

  typedef enum logic {
    MODE_SLOT = 1'b0,
    MODE_RR   = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits, including for n == 1 or 2.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - rotating-priority picker: first set bit of mask from start upward
module rr_picker
  import equal_opp_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int IDW = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] mask_i,
  input  logic [IDW-1:0]  start_i,
  output logic            valid_o,
  output logic [IDW-1:0]  index_o
);

  logic [2*N_CH-1:0] dbl_mask;

  assign dbl_mask = {mask_i, mask_i};

  // Scan the duplicated mask inside the window [start, start+N_CH); the lowest hit wins.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    for (int j = 0; j < 2 * N_CH; j++) begin
      if (!valid_o && dbl_mask[j] &&
          (j >= int'(start_i)) && (j < int'(start_i) + N_CH)) begin
        valid_o = 1'b1;
        index_o = IDW'(j % N_CH);
      end
    end
  end

endmodule

// File: rtl/equal_opp_rr_arbiter.sv
// rtl/equal_opp_rr_arbiter.sv - N-channel fair arbiter with slot or round-robin mode and starvation flags
module equal_opp_rr_arbiter
  import equal_opp_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int QUANTUM  = 2,
  parameter int MODE     = 1,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 16,
  localparam int IDW = clog2_min1(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] gnt,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  output logic [N_CH-1:0] starve
);

  localparam int  QW    = clog2_min1(QUANTUM);
  localparam bit  IS_RR = (MODE == int'(MODE_RR));

  arb_state_e        state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    owner_q, owner_d;
  // Quantum counter in RR mode, slot-position counter in slot mode.
  logic [QW-1:0]     qcnt_q, qcnt_d;
  logic [N_CH-1:0]   gnt_q, gnt_d;
  logic              gnt_valid_q;
  logic [IDW-1:0]    gnt_id_q, gnt_id_d;
  logic [WAIT_W-1:0] wait_q [N_CH];
  logic [WAIT_W-1:0] wait_d [N_CH];
  logic [N_CH-1:0]   starve_q, starve_d;

  logic [N_CH-1:0]   pick_mask;
  logic [IDW-1:0]    pick_start;
  logic              pick_valid;
  logic [IDW-1:0]    pick_idx;

  function automatic logic [N_CH-1:0] onehot(input logic [IDW-1:0] idx);
    logic [N_CH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] idx);
    return (idx == IDW'(N_CH - 1)) ? '0 : idx + IDW'(1);
  endfunction

  rr_picker #(.N_CH(N_CH)) u_picker (
    .mask_i  (pick_mask),
    .start_i (pick_start),
    .valid_o (pick_valid),
    .index_o (pick_idx)
  );

  // Next-state for the rotation pointer, RR ownership and the registered grant.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    qcnt_d     = qcnt_q;
    gnt_d      = '0;
    pick_mask  = '0;
    pick_start = '0;
    if (!IS_RR) begin
      // Slots rotate regardless of demand; only the slot owner can be granted.
      if (qcnt_q == QW'(QUANTUM - 1)) begin
        qcnt_d = '0;
        ptr_d  = inc_mod(ptr_q);
      end else begin
        qcnt_d = qcnt_q + QW'(1);
      end
      gnt_d = onehot(ptr_d) & req;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pick_mask  = req;
          pick_start = ptr_q;
          if (pick_valid) begin
            owner_d = pick_idx;
            qcnt_d  = '0;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          pick_mask  = req & ~onehot(owner_q);
          pick_start = inc_mod(owner_q);
          if (!req[owner_q] || (qcnt_q == QW'(QUANTUM - 1))) begin
            // Release: hand off in the same edge when someone else waits.
            ptr_d  = inc_mod(owner_q);
            qcnt_d = '0;
            if (pick_valid) begin
              owner_d = pick_idx;
            end else if (!req[owner_q]) begin
              state_d = ST_IDLE;
            end
          end else begin
            qcnt_d = qcnt_q + QW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (state_d == ST_BUSY) begin
        gnt_d = onehot(owner_d);
      end
    end
  end

  // Encode the index of the next grant.
  always_comb begin
    gnt_id_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_d[i]) begin
        gnt_id_d = IDW'(i);
      end
    end
  end

  // Per-channel wait time against the currently visible grant, saturating.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      if (req[i] && !gnt_q[i]) begin
        wait_d[i] = (wait_q[i] == {WAIT_W{1'b1}}) ? wait_q[i] : wait_q[i] + WAIT_W'(1);
      end else begin
        wait_d[i] = '0;
      end
      starve_d[i] = (wait_d[i] >= WAIT_W'(MAX_WAIT));
    end
  end

  // State and output registers; reset drops any grant without handoff.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      qcnt_q      <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      starve_q    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      qcnt_q      <= qcnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= |gnt_d;
      gnt_id_q    <= gnt_id_d;
      starve_q    <= starve_d;
      for (int i = 0; i < N_CH; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign starve    = starve_q;

endmodule

// File: tb/tb_equal_opp_rr_arbiter.sv
// tb/tb_equal_opp_rr_arbiter.sv - self-checking bench for equal_opp_rr_arbiter
module tb_equal_opp_rr_arbiter;

  localparam int NC = 4;
  localparam int Q  = 2;

  logic       clk;
  logic       reset;
  logic [3:0] req;

  // Instance 0: RR, MAX_WAIT 16; instance 1: SLOT, MAX_WAIT 4; instance 2: RR, MAX_WAIT 3.
  logic [3:0] gnt_w [3];
  logic       val_w [3];
  logic [1:0] id_w  [3];
  logic [3:0] stv_w [3];

  int n_vec;
  int n_mis;

  // Reference model state: owner -1 means no grant.
  int m_owner [3];
  int m_ten   [3];
  int m_ptr   [3];
  int m_wait  [3][4];
  bit m_starve[3][4];
  int m_edges;

  equal_opp_rr_arbiter #(.N_CH(NC), .QUANTUM(Q), .MODE(1), .WAIT_W(8), .MAX_WAIT(16)) dut_rr (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt_w[0]), .gnt_valid(val_w[0]), .gnt_id(id_w[0]), .starve(stv_w[0]));

  equal_opp_rr_arbiter #(.N_CH(NC), .QUANTUM(Q), .MODE(0), .WAIT_W(8), .MAX_WAIT(4)) dut_slot (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt_w[1]), .gnt_valid(val_w[1]), .gnt_id(id_w[1]), .starve(stv_w[1]));

  equal_opp_rr_arbiter #(.N_CH(NC), .QUANTUM(Q), .MODE(1), .WAIT_W(8), .MAX_WAIT(3)) dut_rr3 (
    .clk(clk), .reset(reset), .req(req),
    .gnt(gnt_w[2]), .gnt_valid(val_w[2]), .gnt_id(id_w[2]), .starve(stv_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int max_wait_of(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 4 : 3);
  endfunction

  // Expected {gnt, gnt_valid, gnt_id, starve} for instance k.
  function automatic logic [10:0] model_out(input int k);
    logic [3:0] g;
    logic [1:0] id;
    logic [3:0] s;
    g  = '0;
    id = '0;
    if (m_owner[k] >= 0) begin
      g[m_owner[k]] = 1'b1;
      id = 2'(m_owner[k]);
    end
    for (int i = 0; i < NC; i++) s[i] = m_starve[k][i];
    return {g, |g, id, s};
  endfunction

  // Advance the reference model by one clock edge, seen from req/reset at that edge.
  task automatic model_step();
    int o, nxt, c;
    if (reset) begin
      m_edges = 0;
      for (int k = 0; k < 3; k++) begin
        m_owner[k] = -1; m_ten[k] = 0; m_ptr[k] = 0;
        for (int i = 0; i < NC; i++) begin m_wait[k][i] = 0; m_starve[k][i] = 1'b0; end
      end
      return;
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NC; i++) begin
        if (req[i] && m_owner[k] != i) m_wait[k][i] = (m_wait[k][i] >= 255) ? 255 : m_wait[k][i] + 1;
        else m_wait[k][i] = 0;
        m_starve[k][i] = (m_wait[k][i] >= max_wait_of(k));
      end
    end
    m_edges++;
    // Slot mode: the owner is simply the slot number after this edge.
    o = (m_edges / Q) % NC;
    m_owner[1] = req[o] ? o : -1;
    for (int k = 0; k < 3; k += 2) begin
      if (m_owner[k] < 0) begin
        nxt = -1;
        for (int d = 0; d < NC; d++) begin
          c = (m_ptr[k] + d) % NC;
          if (nxt < 0 && req[c]) nxt = c;
        end
        if (nxt >= 0) begin m_owner[k] = nxt; m_ten[k] = 1; end
      end else if (!req[m_owner[k]] || m_ten[k] == Q) begin
        o = m_owner[k];
        m_ptr[k] = (o + 1) % NC;
        nxt = -1;
        for (int d = 1; d < NC; d++) begin
          c = (o + d) % NC;
          if (nxt < 0 && req[c]) nxt = c;
        end
        if (nxt >= 0) begin m_owner[k] = nxt; m_ten[k] = 1; end
        else if (req[o]) m_ten[k] = 1;
        else m_owner[k] = -1;
      end else begin
        m_ten[k]++;
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, update the model, settle on the falling edge.
  task automatic cycle(input logic rst, input logic [3:0] r);
    reset = rst;
    req   = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1'b1, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({gnt_w[k], val_w[k], id_w[k], stv_w[k]} !== 11'd0) begin
        n_mis++;
        $display("FAIL reset_state inst=%0d got=%h want=000", k, {gnt_w[k], val_w[k], id_w[k], stv_w[k]});
      end
    end
  endtask

  task automatic test_sole_requester();
    cycle(1'b1, 4'b0000);
    for (int t = 0; t < 6; t++) begin
      cycle(1'b0, 4'b0100);
      n_vec++;
      if (gnt_w[0] !== 4'b0100 || id_w[0] !== 2'd2 || stv_w[0] !== 4'b0000) begin
        n_mis++;
        $display("FAIL sole_req t=%0d got gnt=%b id=%0d starve=%b want gnt=0100 id=2 starve=0000", t, gnt_w[0], id_w[0], stv_w[0]);
      end
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if ({gnt_w[k], val_w[k], id_w[k], stv_w[k]} !== model_out(k)) begin
          n_mis++;
          $display("FAIL sole_model inst=%0d t=%0d got=%h want=%h", k, t, {gnt_w[k], val_w[k], id_w[k], stv_w[k]}, model_out(k));
        end
      end
    end
  endtask

  task automatic test_all_request();
    int order [12];
    order = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1};
    cycle(1'b1, 4'b0000);
    for (int t = 0; t < 12; t++) begin
      cycle(1'b0, 4'b1111);
      n_vec++;
      if (gnt_w[0] !== (4'b0001 << order[t]) || stv_w[0] !== 4'b0000) begin
        n_mis++;
        $display("FAIL rr_order t=%0d got gnt=%b starve=%b want ch%0d starve=0000", t, gnt_w[0], stv_w[0], order[t]);
      end
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if ({gnt_w[k], val_w[k], id_w[k], stv_w[k]} !== model_out(k)) begin
          n_mis++;
          $display("FAIL all_model inst=%0d t=%0d got=%h want=%h", k, t, {gnt_w[k], val_w[k], id_w[k], stv_w[k]}, model_out(k));
        end
      end
    end
  endtask

  task automatic test_handoff();
    logic [3:0] seq [5];
    seq = '{4'b0010, 4'b1010, 4'b1000, 4'b1000, 4'b1000};
    cycle(1'b1, 4'b0000);
    for (int t = 0; t < 5; t++) begin
      cycle(1'b0, seq[t]);
      if (t == 2) begin
        n_vec++;
        if (gnt_w[0] !== 4'b1000) begin
          n_mis++;
          $display("FAIL handoff_no_bubble got gnt=%b want 1000", gnt_w[0]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if ({gnt_w[k], val_w[k], id_w[k], stv_w[k]} !== model_out(k)) begin
          n_mis++;
          $display("FAIL handoff_model inst=%0d t=%0d got=%h want=%h", k, t, {gnt_w[k], val_w[k], id_w[k], stv_w[k]}, model_out(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    cycle(1'b1, 4'b0000);
    cycle(1'b0, 4'b0010);
    n_vec++;
    if (gnt_w[0] !== 4'b0010) begin
      n_mis++;
      $display("FAIL pre_reset_grant got gnt=%b want 0010", gnt_w[0]);
    end
    cycle(1'b1, 4'b0010);
    n_vec++;
    if (gnt_w[0] !== 4'b0000 || stv_w[0] !== 4'b0000 || val_w[0] !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_mid_grant got gnt=%b valid=%b starve=%b want 0000/0/0000", gnt_w[0], val_w[0], stv_w[0]);
    end
    cycle(1'b0, 4'b0011);
    n_vec++;
    if (gnt_w[0] !== 4'b0001 || id_w[0] !== 2'd0) begin
      n_mis++;
      $display("FAIL after_reset_pick got gnt=%b id=%0d want 0001 id=0", gnt_w[0], id_w[0]);
    end
  endtask

  task automatic test_slot_rotation();
    int grants;
    bit saw_starve;
    grants = 0;
    saw_starve = 1'b0;
    cycle(1'b1, 4'b0000);
    for (int t = 0; t < 24; t++) begin
      cycle(1'b0, 4'b0001);
      if (gnt_w[1] === 4'b0001) grants++;
      if (stv_w[1][0] === 1'b1) saw_starve = 1'b1;
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if ({gnt_w[k], val_w[k], id_w[k], stv_w[k]} !== model_out(k)) begin
          n_mis++;
          $display("FAIL slot_model inst=%0d t=%0d got=%h want=%h", k, t, {gnt_w[k], val_w[k], id_w[k], stv_w[k]}, model_out(k));
        end
      end
    end
    n_vec++;
    if (grants !== 6) begin
      n_mis++;
      $display("FAIL slot_grant_count got %0d want 6", grants);
    end
    n_vec++;
    if (saw_starve !== 1'b1) begin
      n_mis++;
      $display("FAIL slot_starve got no starve[0] want asserted");
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rst;
    r = 4'b0000;
    cycle(1'b1, 4'b0000);
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 99) == 0);
      cycle(rst, r);
      n_vec++;
      if (stv_w[0] !== 4'b0000) begin
        n_mis++;
        $display("FAIL rr_fairness t=%0d got starve=%b want 0000", t, stv_w[0]);
      end
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if ({gnt_w[k], val_w[k], id_w[k], stv_w[k]} !== model_out(k)) begin
          n_mis++;
          $display("FAIL random_model inst=%0d t=%0d req=%b got=%h want=%h", k, t, r, {gnt_w[k], val_w[k], id_w[k], stv_w[k]}, model_out(k));
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    reset = 1'b1;
    req   = 4'b0000;
    @(negedge clk);
    test_reset();
    test_sole_requester();
    test_all_request();
    test_handoff();
    test_reset_mid_grant();
    test_slot_rotation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
